// File: rtl/branch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// branch_pc_ctrl
//   Program-counter sequencer and redirect controller for the branch unit.
//   Owns the fetch PC, drives the instruction-memory request handshake, and
//   redirects fetch when the EX-stage branch unit resolves a taken branch or
//   an unconditional jump. The wrong-path IF/ID instructions are flushed
//   under a static not-taken policy.
//
// Parameters
//   RESET_PC : fetch address loaded on reset (4-byte aligned)
//   STAT_W   : width of the optional statistics counters
//
// Ports
//   clk, rst    : clock and synchronous active-high reset
//   br_op       : EX branch opcode ([4]=jump, [4:3]=01 conditional, 00 none)
//   jump        : branch unit decision for the EX instruction
//   target      : computed branch/jump target
//   ex_valid    : EX holds a real instruction
//   stall       : front-end stall from the hazard unit
//   imem_ready  : instruction memory accepts the request this cycle
//   imem_req    : fetch request
//   pc          : current fetch address (registered)
//   pc_plus4    : pc + 4 (combinational, wraps modulo 2^32)
//   fetch_valid : fetch accepted this cycle
//   flush       : kill IF/ID this cycle
//   misalign    : sticky misaligned-target error
//
// Optional feature (macro BRANCH_STATS_EN)
//   br_count, taken_count, stall_count : wrapping statistics counters.
// -----------------------------------------------------------------------------
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        br_op,
  input  logic              jump,
  input  logic [31:0]       target,
  input  logic              ex_valid,
  input  logic              stall,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              fetch_valid,
  output logic              flush,
  output logic              misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] taken_count,
  output logic [STAT_W-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_SHADOW = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;

  logic        is_branch;
  logic        redirect;
  logic [31:0] eff_target;

  // Redirects are only honoured in RUN: in SHADOW the EX slot holds the
  // bubble created by the previous flush, so its ex_valid/jump are stale.
  assign is_branch  = ex_valid && (br_op[4:3] != 2'b00);
  assign redirect   = (state_q == S_RUN) && is_branch && (br_op[4] || jump);
  assign eff_target = {target[31:1], 1'b0};

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign misalign    = misalign_q;
  assign fetch_valid = imem_req && imem_ready;

  // Next-state, next-PC and handshake/flush outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    imem_req   = 1'b0;
    flush      = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN, S_SHADOW: begin
        if (redirect) begin
          // Redirect wins over stall and over a ready memory this cycle.
          flush = 1'b1;
          if (eff_target[1]) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d    = eff_target;
            state_d = S_SHADOW;
          end
        end else begin
          imem_req = !stall;
          state_d  = S_RUN;
          if (!stall && imem_ready) begin
            pc_d = pc_plus4;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State, PC and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] br_count_q, br_count_d;
  logic [STAT_W-1:0] taken_count_q, taken_count_d;
  logic [STAT_W-1:0] stall_count_q, stall_count_d;

  // Counter increments; every redirect (aligned or not) counts as taken.
  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    stall_count_d = stall_count_q;
    if ((state_q == S_RUN) && is_branch) begin
      br_count_d = br_count_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      br_count_d = br_count_q;
    end
    if (redirect) begin
      taken_count_d = taken_count_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      taken_count_d = taken_count_q;
    end
    if (((state_q == S_RUN) || (state_q == S_SHADOW)) && stall) begin
      stall_count_d = stall_count_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
  assign stall_count = stall_count_q;
`else
  // Opcode sub-field and target bit 0 carry no meaning for sequencing.
  logic unused_inputs_s;
  assign unused_inputs_s = ^{br_op[2:0], target[0], (STAT_W < 1)};
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
module tb_branch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          SW     = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  br_op;
  logic        jump;
  logic [31:0] target;
  logic        ex_valid;
  logic        stall;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        misalign;
`ifdef BRANCH_STATS_EN
  logic [SW-1:0] br_count, taken_count, stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: abstract front-end phase flags plus counters.
  logic [31:0] m_pc;
  bit          m_boot, m_shadow, m_halt, m_mis;
  int unsigned m_br, m_taken, m_stall;

  always #5 clk = ~clk;

  branch_pc_ctrl #(.RESET_PC(RST_PC), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .br_op(br_op), .jump(jump), .target(target),
    .ex_valid(ex_valid), .stall(stall), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .flush(flush), .misalign(misalign)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .taken_count(taken_count), .stall_count(stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_boot = 1; m_shadow = 0; m_halt = 0; m_mis = 0;
    m_br = 0; m_taken = 0; m_stall = 0;
  endtask

  task automatic drive(input bit i_rst, input logic [4:0] i_op, input bit i_jump,
                       input logic [31:0] i_tgt, input bit i_ev, input bit i_stall,
                       input bit i_rdy);
    rst = i_rst; br_op = i_op; jump = i_jump; target = i_tgt;
    ex_valid = i_ev; stall = i_stall; imem_ready = i_rdy;
    #1;
  endtask

  task automatic idle();
    drive(0, 5'd0, 0, 32'd0, 0, 0, 1);
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic tick();
    bit active, is_br, redir, exp_req, exp_fv;
    logic [31:0] tgt;
    active  = !m_boot && !m_halt;
    is_br   = ex_valid && (br_op[4:3] != 2'b00);
    redir   = active && !m_shadow && is_br && (br_op[4] || jump);
    exp_req = active && !redir && !stall;
    exp_fv  = exp_req && imem_ready;
    tgt     = {target[31:1], 1'b0};
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, exp_fv});
    check("flush", {31'd0, flush}, {31'd0, redir});
    check("misalign", {31'd0, misalign}, {31'd0, m_mis});
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (active && !m_shadow && is_br) m_br++;
      if (redir) m_taken++;
      if (active && stall) m_stall++;
      if (m_boot) m_boot = 0;
      else if (m_halt) m_halt = 1;
      else if (redir) begin
        if (tgt[1]) begin m_halt = 1; m_mis = 1; end
        else begin m_pc = tgt; m_shadow = 1; end
      end else begin
        m_shadow = 0;
        if (exp_fv) m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, "_br"}, br_count, m_br);
    check({tag, "_taken"}, taken_count, m_taken);
    check({tag, "_stall"}, stall_count, m_stall);
`else
    check({tag, "_mis_off"}, {31'd0, misalign}, {31'd0, m_mis});
`endif
  endtask

  initial begin
    drive(1, 5'd0, 0, 32'd0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_pc", pc, RST_PC);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_fv", {31'd0, fetch_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);

    // Boot then sequential fetch.
    idle(); check("boot_req", {31'd0, imem_req}, 32'd0); tick();
    idle(); check("seq0", pc, 32'h100); check("seq0_fv", {31'd0, fetch_valid}, 32'd1); tick();
    idle(); check("seq1", pc, 32'h104); tick();
    idle(); check("seq2", pc, 32'h108); tick();

    // Jump to 0x200, hold there through the shadow cycle.
    drive(0, 5'b10000, 0, 32'h200, 1, 0, 1); tick();
    drive(0, 5'd0, 0, 32'd0, 0, 1, 1); tick();
    // Conditional taken branch to 0x80.
    drive(0, 5'b01000, 1, 32'h80, 1, 0, 1);
    check("br_pc", pc, 32'h200);
    check("br_flush", {31'd0, flush}, 32'd1);
    check("br_req", {31'd0, imem_req}, 32'd0);
    tick();
    idle(); check("tgt_pc", pc, 32'h80); check("tgt_req", {31'd0, imem_req}, 32'd1); tick();
    idle(); check("tgt_pc4", pc, 32'h84); tick();

    // Not taken, then unconditional with odd target.
    drive(0, 5'b01001, 0, 32'h900, 1, 0, 1); check("nt_flush", {31'd0, flush}, 32'd0); tick();
    idle(); check("nt_pc", pc, 32'h8C); tick();
    drive(0, 5'b10000, 0, 32'h301, 1, 0, 1); check("uj_flush", {31'd0, flush}, 32'd1); tick();
    idle(); check("uj_pc", pc, 32'h300); tick();

    // Stall at 0x40.
    drive(0, 5'b10000, 0, 32'h40, 1, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'd0, 0, 32'd0, 0, 1, 1);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      tick();
      check("stall_pc", pc, 32'h40);
    end
    idle(); tick(); check("unstall_pc", pc, 32'h44);
    drive(0, 5'd0, 0, 32'd0, 0, 0, 0); check("wait_req", {31'd0, imem_req}, 32'd1); tick();
    check("wait_pc", pc, 32'h44);
    idle(); tick();

    // Redirect during stall.
    drive(0, 5'b10000, 0, 32'h500, 1, 1, 1); check("rds_flush", {31'd0, flush}, 32'd1); tick();
    check("rds_pc", pc, 32'h500);
    idle(); tick();

    // Wrap-around.
    drive(0, 5'b10000, 0, 32'hFFFF_FFFC, 1, 0, 1); tick();
    idle(); check("wrap_pre", pc, 32'hFFFF_FFFC); tick();
    check("wrap_pc", pc, 32'h0);

    // Misaligned target -> HALT.
    drive(0, 5'b10000, 0, 32'h1006, 1, 0, 1); check("mis_flush", {31'd0, flush}, 32'd1); tick();
    check("mis_flag", {31'd0, misalign}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      drive(0, 5'b10000, 1, 32'h2000, 1, 0, 1);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      tick();
    end
    check("halt_pc", pc, 32'h0);
    drive(1, 5'd0, 0, 32'd0, 0, 0, 1); tick();
    idle(); check("rec_pc", pc, RST_PC); check("rec_mis", {31'd0, misalign}, 32'd0); tick();

    // Statistics: 3 branches (2 taken) plus 4 stall cycles after reset.
    drive(1, 5'd0, 0, 32'd0, 0, 0, 1); tick();
    idle(); tick();
    drive(0, 5'b01000, 1, 32'h1000, 1, 0, 1); tick();
    idle(); tick();
    drive(0, 5'b01000, 0, 32'h3000, 1, 0, 1); tick();
    drive(0, 5'b10000, 0, 32'h2000, 1, 0, 1); tick();
    idle(); tick();
    for (int i = 0; i < 4; i++) begin drive(0, 5'd0, 0, 32'd0, 0, 1, 1); tick(); end
    idle(); tick();
`ifdef BRANCH_STATS_EN
    check("st_br", br_count, 32'd3);
    check("st_taken", taken_count, 32'd2);
    check("st_stall", stall_count, 32'd4);
`endif
    check_stats("st_model");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom & 32'hFFFF_FFFD;
      if ($urandom_range(0, 15) == 0) t = t | 32'h2;
      drive($urandom_range(0, 63) == 0, 5'($urandom), 1'($urandom), t,
            1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      tick();
    end
    idle(); check_stats("rand_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
Program-counter sequencer and redirect controller for the branch unit.
- Owns the fetch PC and drives the instruction-memory request handshake.
- Consumes the branch unit's jump decision for the instruction in EX and redirects fetch.
- Flushes the wrong-path IF/ID instructions under a static not-taken policy.
- Sits between the hazard unit, instruction memory and the EX-stage branch unit.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; must be 4-byte aligned.
- STAT_W, 32, width of the optional statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- br_op  in  5  branch opcode of the EX instruction: [4]=1 unconditional jump; [4:3]=01 conditional; [4:3]=00 not a branch.
- jump  in  1  branch unit decision for the EX instruction.
- target  in  32  computed branch/jump target from EX.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- stall  in  1  hazard-unit stall request for the front end.
- imem_ready  in  1  instruction memory accepts the request this cycle.
- imem_req  out  1  fetch request.
- pc  out  32  current fetch address, registered.
- pc_plus4  out  32  pc + 4, combinational.
- fetch_valid  out  1  fetch accepted this cycle (imem_req && imem_ready).
- flush  out  1  kill IF/ID contents this cycle.
- misalign  out  1  sticky misaligned-target error.

Behaviour:
- Reset values: pc=RESET_PC, imem_req=0, fetch_valid=0, flush=0, misalign=0, state=BOOT. A reset asserted in any state, including HALT, returns to these values on the next edge.
- States:
  - BOOT: single cycle after reset deasserts. imem_req=0. Always goes to RUN.
  - RUN: normal operation.
  - SHADOW: one cycle after a redirect.
  - HALT: entered on a misaligned target.
- Redirect condition: redirect = ex_valid && br_op[4:3]!=2'b00 && (br_op[4] || jump).
- Target handling: eff_target = {target[31:1],1'b0}, so bit 0 is always cleared.
- RUN, no redirect:
  - imem_req = !stall.
  - On imem_req && imem_ready: pc <= pc+4 and fetch_valid=1.
  - On stall or !imem_ready: pc holds.
- RUN, redirect with eff_target[1]==0:
  - Same cycle, combinationally: flush=1, imem_req=0, fetch_valid=0.
  - Next edge: pc <= eff_target, state <= SHADOW.
  - Redirect has priority over stall and over an imem_ready in the same cycle.
- RUN, redirect with eff_target[1]==1:
  - flush=1 that cycle; misalign <= 1; pc holds; state <= HALT.
- SHADOW:
  - Behaves as RUN for fetch (imem_req = !stall).
  - ex_valid/jump are ignored because EX holds the flushed bubble.
  - Goes to RUN on the next edge regardless of stall.
- HALT: imem_req=0 and flush=0. misalign stays 1. Only rst exits.
- Latency: the first fetch from the target is requested one cycle after the redirect cycle. The taken-branch penalty is 2 cycles (IF and ID killed).
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Invariant: flush is never asserted outside a redirect cycle.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, add three outputs:
  - br_count[STAT_W-1:0]: increments on ex_valid && br_op[4:3]!=00 in RUN.
  - taken_count[STAT_W-1:0]: increments on every redirect, including misaligned ones.
  - stall_count[STAT_W-1:0]: increments on each RUN/SHADOW cycle where stall=1.
- All three clear on rst and wrap modulo 2^STAT_W.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h100, imem_ready=1, no stall:
  - Cycle after rst deasserts: BOOT, imem_req=0.
  - Then pc=0x100, 0x104, 0x108 on consecutive cycles with fetch_valid=1.
- pc=0x200, ex_valid=1, br_op=5'b01000, jump=1, target=0x80:
  - flush=1 and imem_req=0 that cycle.
  - Next cycle pc=0x80, imem_req=1.
  - Cycle after that pc=0x84.
- Not-taken and unconditional cases:
  - br_op=5'b01001, jump=0 → no flush, pc increments normally.
  - br_op=5'b10000, jump=0, target=0x301 → redirect to 0x300 (bit 0 cleared).
- Stall and memory wait:
  - stall=1 for 3 cycles at pc=0x40 → imem_req=0 and pc holds 0x40; increments after release.
  - imem_ready=0 → pc holds with imem_req=1.
  - Redirect during stall → flush=1 and pc loads the target anyway.
- Misaligned target: redirect with target=0x1006 → flush=1 and misalign=1; HALT with imem_req=0 for 10+ cycles; rst restores pc=RESET_PC and misalign=0.
- Wrap and stats:
  - pc=0xFFFF_FFFC accepted → pc=0x0.
  - With BRANCH_STATS_EN: 3 branches (2 taken) plus 4 stall cycles → br_count=3, taken_count=2, stall_count=4.
